johnson_seq_ctrl: RTL
=====================

Name: johnson_seq_ctrl

Overview:
- Sequencer for an 8-bit Johnson (twisted-ring) counter: owns the ring register and steps it at a programmable rate.
- Runs a programmable number of steps, or runs continuously, in either direction.
- Supports a guarded parallel load with illegal-code detection, and reports busy/done/error status plus a 0..15 phase index.
- Sits between the lab control logic (switches/buttons) and the display/decoder that consumes q.

Parameters:
WIDTH, 8, ring width in bits; phase output is sized for 2*WIDTH states.
DIV_W, 8, width of the prescaler divisor input.
STEP_W, 5, width of the step-count input.

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  synchronous active-high reset.
start  in  1  request to begin a run; sampled only in IDLE.
stop  in  1  abort the run; effective in RUN and DONE.
dir  in  1  0 = forward (shift toward MSB), 1 = reverse; latched at start.
div  in  DIV_W  prescaler; one step every div+1 clk cycles; latched at start.
steps  in  STEP_W  number of steps to run; 0 = continuous; latched at start.
load  in  1  parallel load request; honoured only in IDLE.
load_val  in  WIDTH  value to load into the ring.
q  out  WIDTH  ring register.
phase  out  4  Johnson state index 0..15 derived from q.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse when a counted run completes.
err  out  1  sticky flag: an illegal code was offered on load; cleared only by clr.

Behaviour:
- Clock and reset: one clock, clk. clr is synchronous and active-high.
- Reset values: q=0, state=IDLE, busy=0, done=0, err=0, prescaler=0, remaining=0, so phase=0.
- Forward step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}. Sequence: 00000000 -> 00000001 -> 00000011 ... -> 11111111 -> 11111110 ... -> 10000000 -> 00000000.
- Reverse step: q <= {~q[0], q[WIDTH-1:1]}. This is the exact inverse of the forward step.
- Phase decode (combinational): if q[MSB]==0, phase = number of ones in q; otherwise phase = 8 + number of zeros in q.
- Legal codes: the 16 codes above. Any other code is illegal.
- States: IDLE, RUN, DONE.
- IDLE:
  - load=1: if load_val is legal, q <= load_val; else q <= 0 and err <= 1. start is ignored in the same cycle (load has priority).
  - start=1 and load=0: latch dir, div and steps; remaining <= steps; prescaler <= 0; go to RUN. busy rises on the next cycle.
  - stop is ignored.
- RUN:
  - Prescaler counts 0..div_latched. When it equals div_latched, that cycle is a tick and the prescaler wraps to 0.
  - First shift happens div+1 cycles after the start-accept edge. With div=0, q steps every clk.
  - On a tick, q shifts per dir_latched.
  - If steps_latched != 0, remaining decrements on each tick. The tick that takes remaining from 1 to 0 shifts q and moves to DONE.
  - If steps_latched == 0, the run never ends on its own.
  - stop=1: go to IDLE next cycle. Any tick in that same cycle is suppressed (q unchanged). No done pulse.
  - start, load and changes on div/dir/steps are ignored.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. stop in DONE has no additional effect.
- Wrap-around: the ring wraps 10000000 -> 00000000 (forward) and 00000000 -> 10000000 (reverse) with no special handling.
- clr in any state returns everything to reset values in the next cycle; a run in progress is abandoned with no done pulse.
- done and busy are never high in the same cycle.
- Outputs are registered except phase, which is combinational from q.

Test Plan:
1. Reset then forward count: clr=1 for 2 cycles, then dir=0, div=0, steps=16, start pulse -> q walks 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00. done pulses once after the 16th shift. phase runs 1..15 then 0. busy=1 for exactly 16 cycles.
2. Prescaled reverse run: div=3, dir=1, steps=4, q=00 -> shifts every 4 cycles, giving 80, C0, E0, F0. done pulses 16 cycles after start is accepted. phase reads 15, 14, 13, 12.
3. Load legality: in IDLE, load with load_val=0x1F -> q=1F, phase=5, err=0. Then load with load_val=0x5A -> q=00, err=1. err stays 1 through a subsequent run and clears only on clr.
4. Continuous run and stop: steps=0, div=0 -> q cycles through all 16 codes repeatedly with no done. Assert stop in the cycle of a tick with q=0x07 -> q stays 07 and the FSM is in IDLE next cycle. done is never pulsed.
5. Ignored inputs while running: during RUN, pulse start and load (load_val=0xFF) and change dir -> sequence and step count are unaffected. Same-cycle start+load in IDLE -> load only, state stays IDLE.
6. Reset mid-run: clr asserted while q=0x3F and busy=1 -> next cycle q=00, busy=0, done=0, phase=0, and the FSM stays in IDLE until a new start.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Johnson twisted-ring sequencer: programmable-rate stepping, counted or
// continuous runs in either direction, guarded load with illegal-code flag.
module johnson_seq_ctrl #(
   parameter  int WIDTH  = 8,
   parameter  int DIV_W  = 8,
   parameter  int STEP_W = 5,
   localparam int PW     = $clog2(2*WIDTH)
)(
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              stop,
   input  logic              dir,
   input  logic [DIV_W-1:0]  div,
   input  logic [STEP_W-1:0] steps,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  q,
   output logic [PW-1:0]     phase,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic              dir_l;
   logic              cont;
   logic [DIV_W-1:0]  div_l;
   logic [DIV_W-1:0]  pre;
   logic [STEP_W-1:0] rem;

   logic [WIDTH-1:0]  q_fwd;
   logic [WIDTH-1:0]  q_rev;
   logic [WIDTH-1:0]  q_next;
   logic [WIDTH-2:0]  edges;
   logic              legal;
   logic              tick;
   logic [PW-1:0]     ones;

   assign q_fwd  = {q[WIDTH-2:0], ~q[WIDTH-1]};
   assign q_rev  = {~q[0], q[WIDTH-1:1]};
   assign q_next = dir_l ? q_rev : q_fwd;
   assign tick   = (pre == div_l);

   // A legal code has at most one adjacent-bit transition (no wrap).
   assign edges = load_val[WIDTH-1:1] ^ load_val[WIDTH-2:0];
   assign legal = ((edges & (edges - (WIDTH-1)'(1))) == '0);

   always_comb begin
      ones = '0;
      for (int i = 0; i < WIDTH; i++)
         ones = ones + {{(PW-1){1'b0}}, q[i]};
   end

   // With MSB set, phase = WIDTH + zeros = 2*WIDTH - ones.
   assign phase = q[WIDTH-1] ? PW'(2*WIDTH - int'(ones)) : ones;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         pre   <= '0;
         rem   <= '0;
         dir_l <= 1'b0;
         div_l <= '0;
         cont  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (load) begin
                  if (legal) begin
                     q <= load_val;
                  end else begin
                     q   <= '0;
                     err <= 1'b1;
                  end
               end else if (start) begin
                  dir_l <= dir;
                  div_l <= div;
                  cont  <= (steps == '0);
                  rem   <= steps;
                  pre   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (tick) begin
                  pre <= '0;
                  q   <= q_next;
                  if (!cont) begin
                     rem <= rem - STEP_W'(1);
                     if (rem == STEP_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end
               end else begin
                  pre <= pre + DIV_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
